// File: rtl/mure_pkg.sv
// Shared types and widths for the retirement packer: entry layouts and fill-buffer state.
package mure_pkg;

  localparam int unsigned ITYPE_LEN = 3;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned CAUSE_LEN = 5;
  localparam int unsigned TVAL_LEN  = 32;
  localparam int unsigned PRIV_LEN  = 2;

  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = 3'd1;
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT = 3'd2;

  typedef struct packed {
    logic                 iretire;
    logic                 ilastsize;
    logic [ITYPE_LEN-1:0] itype;
    logic [XLEN-1:0]      iaddr;
  } uop_entry_s;

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [TVAL_LEN-1:0]  tval;
    logic [PRIV_LEN-1:0]  priv;
  } common_entry_s;

  typedef enum logic [1:0] {
    FILL_EMPTY   = 2'd0,
    FILL_PARTIAL = 2'd1,
    FILL_CLOSED  = 2'd2
  } fill_state_e;

endpackage

// File: rtl/retire_packer.sv
// Repacks a serial retirement stream into lane groups via a fill buffer and an output register.
// Optional partial-group idle timeout: define MURE_PACKER_TIMEOUT_EN.
module retire_packer
  import mure_pkg::*;
#(
  parameter int unsigned NrRetiredInstr = 2,
  parameter int unsigned TimeoutCycles  = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     valid_i,
  output logic                                     ready_o,
  input  logic                                     iretire_i,
  input  logic                                     ilastsize_i,
  input  logic [ITYPE_LEN-1:0]                     itype_i,
  input  logic [XLEN-1:0]                          iaddr_i,
  input  logic [CAUSE_LEN-1:0]                     cause_i,
  input  logic [TVAL_LEN-1:0]                      tval_i,
  input  logic [PRIV_LEN-1:0]                      priv_i,
  input  logic                                     flush_i,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  output logic [NrRetiredInstr-1:0]                lane_valid_o,
  output logic [NrRetiredInstr-1:0]                iretire_o,
  output logic [NrRetiredInstr-1:0]                ilastsize_o,
  output logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0] itype_o,
  output logic [NrRetiredInstr-1:0][XLEN-1:0]      iaddr_o,
  output logic [CAUSE_LEN-1:0]                     cause_o,
  output logic [TVAL_LEN-1:0]                      tval_o,
  output logic [PRIV_LEN-1:0]                      priv_o
);

  localparam int unsigned CntW = $clog2(NrRetiredInstr + 1);

  fill_state_e                      state_q, state_d;
  logic [CntW-1:0]                  cnt_q, cnt_d;
  uop_entry_s [NrRetiredInstr-1:0]  lanes_q, lanes_d;
  common_entry_s                    comm_q, comm_d;

  logic                             out_valid_q, out_valid_d;
  logic [NrRetiredInstr-1:0]        out_mask_q, out_mask_d;
  uop_entry_s [NrRetiredInstr-1:0]  out_lanes_q, out_lanes_d;
  common_entry_s                    out_comm_q, out_comm_d;

  uop_entry_s                       in_uop_s;
  common_entry_s                    in_comm_s;
  uop_entry_s [NrRetiredInstr-1:0]  grp_lanes_s;
  logic [CntW-1:0]                  grp_cnt_s;
  common_entry_s                    grp_comm_s;
  logic [NrRetiredInstr-1:0]        grp_mask_s;
  logic                             out_free_s, ready_s, accept_s, is_trap_s;
  logic                             close_s, transfer_s, tmo_hit_s;

`ifdef MURE_PACKER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;

  // Idle cycles spent in PARTIAL; any accept or leaving PARTIAL restarts the count.
  always_comb begin
    tmo_d     = '0;
    tmo_hit_s = 1'b0;
    if (state_q == FILL_PARTIAL && !accept_s) begin
      tmo_d     = tmo_q + TmoW'(1);
      tmo_hit_s = (tmo_q == TmoW'(TimeoutCycles - 1));
    end else begin
      tmo_d     = '0;
      tmo_hit_s = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo_s;
  assign unused_tmo_s = ^TimeoutCycles;
  assign tmo_hit_s    = 1'b0;
`endif

  always_comb begin
    in_uop_s   = '{iretire: iretire_i, ilastsize: ilastsize_i, itype: itype_i, iaddr: iaddr_i};
    in_comm_s  = '{cause: cause_i, tval: tval_i, priv: priv_i};
    out_free_s = !out_valid_q || ready_i;
    is_trap_s  = (itype_i == ITYPE_EXC) || (itype_i == ITYPE_INT);

    case (state_q)
      FILL_EMPTY:   ready_s = 1'b1;
      FILL_PARTIAL: ready_s = !(valid_i && (priv_i != comm_q.priv));
      FILL_CLOSED:  ready_s = out_free_s;
      default:      ready_s = 1'b0;
    endcase
    accept_s = valid_i && ready_s;

    // Candidate group: the buffer, plus the incoming entry when it joins this group.
    grp_lanes_s = lanes_q;
    grp_cnt_s   = cnt_q;
    grp_comm_s  = comm_q;
    if (state_q != FILL_CLOSED && accept_s) begin
      for (int i = 0; i < int'(NrRetiredInstr); i++) begin
        if (CntW'(i) == cnt_q) grp_lanes_s[i] = in_uop_s;
        else                   grp_lanes_s[i] = lanes_q[i];
      end
      grp_cnt_s  = cnt_q + CntW'(1);
      grp_comm_s = in_comm_s;
    end else begin
      grp_cnt_s  = cnt_q;
    end
    for (int i = 0; i < int'(NrRetiredInstr); i++) begin
      grp_mask_s[i] = (CntW'(i) < grp_cnt_s);
    end

    case (state_q)
      FILL_EMPTY:   close_s = accept_s && is_trap_s;
      FILL_PARTIAL: close_s = (accept_s && (is_trap_s || grp_cnt_s == CntW'(NrRetiredInstr)))
                              || !ready_s || flush_i || tmo_hit_s;
      FILL_CLOSED:  close_s = 1'b1;
      default:      close_s = 1'b0;
    endcase
    transfer_s = close_s && out_free_s;

    state_d = state_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    comm_d  = comm_q;
    if (state_q == FILL_CLOSED) begin
      if (transfer_s && accept_s) begin
        lanes_d    = '0;
        lanes_d[0] = in_uop_s;
        cnt_d      = CntW'(1);
        comm_d     = in_comm_s;
        state_d    = is_trap_s ? FILL_CLOSED : FILL_PARTIAL;
      end else if (transfer_s) begin
        lanes_d = '0;
        cnt_d   = '0;
        comm_d  = '0;
        state_d = FILL_EMPTY;
      end else begin
        state_d = FILL_CLOSED;
      end
    end else if (transfer_s) begin
      lanes_d = '0;
      cnt_d   = '0;
      comm_d  = '0;
      state_d = FILL_EMPTY;
    end else begin
      lanes_d = grp_lanes_s;
      cnt_d   = grp_cnt_s;
      comm_d  = grp_comm_s;
      if (close_s)                   state_d = FILL_CLOSED;
      else if (grp_cnt_s == CntW'(0)) state_d = FILL_EMPTY;
      else                           state_d = FILL_PARTIAL;
    end

    // Output register is zeroed when consumed so idle lanes and fields read zero.
    out_valid_d = out_valid_q;
    out_mask_d  = out_mask_q;
    out_lanes_d = out_lanes_q;
    out_comm_d  = out_comm_q;
    if (transfer_s) begin
      out_valid_d = 1'b1;
      out_mask_d  = grp_mask_s;
      out_lanes_d = grp_lanes_s;
      out_comm_d  = grp_comm_s;
    end else if (ready_i) begin
      out_valid_d = 1'b0;
      out_mask_d  = '0;
      out_lanes_d = '0;
      out_comm_d  = '0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= FILL_EMPTY;
      cnt_q       <= '0;
      lanes_q     <= '0;
      comm_q      <= '0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_lanes_q <= '0;
      out_comm_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lanes_q     <= lanes_d;
      comm_q      <= comm_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_lanes_q <= out_lanes_d;
      out_comm_q  <= out_comm_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NrRetiredInstr); i++) begin
      iretire_o[i]   = out_lanes_q[i].iretire;
      ilastsize_o[i] = out_lanes_q[i].ilastsize;
      itype_o[i]     = out_lanes_q[i].itype;
      iaddr_o[i]     = out_lanes_q[i].iaddr;
    end
  end

  assign ready_o      = ready_s;
  assign valid_o      = out_valid_q;
  assign lane_valid_o = out_mask_q;
  assign cause_o      = out_comm_q.cause;
  assign tval_o       = out_comm_q.tval;
  assign priv_o       = out_comm_q.priv;

endmodule

// File: tb/tb_retire_packer.sv
// Directed self-checking bench for retire_packer (default parameters, NrRetiredInstr=2).
module tb_retire_packer;
  import mure_pkg::*;

  logic                       clk_i = 1'b0;
  logic                       rst_ni;
  logic                       valid_i, ready_o, iretire_i, ilastsize_i, flush_i, valid_o, ready_i;
  logic [ITYPE_LEN-1:0]       itype_i;
  logic [XLEN-1:0]            iaddr_i;
  logic [CAUSE_LEN-1:0]       cause_i, cause_o;
  logic [TVAL_LEN-1:0]        tval_i, tval_o;
  logic [PRIV_LEN-1:0]        priv_i, priv_o;
  logic [1:0]                 lane_valid_o, iretire_o, ilastsize_o;
  logic [1:0][ITYPE_LEN-1:0]  itype_o;
  logic [1:0][XLEN-1:0]       iaddr_o;

  int n_cmp = 0;
  int n_err = 0;

  retire_packer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i), .iaddr_i(iaddr_i),
    .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .lane_valid_o(lane_valid_o),
    .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o), .iaddr_o(iaddr_o),
    .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one serial entry (or idle when v=0); tval tracks address so the common field is traceable.
  task automatic drv(input logic v, input logic [31:0] a, input logic [2:0] t,
                     input logic [4:0] c, input logic [1:0] p);
    valid_i     = v;
    iaddr_i     = a;
    itype_i     = t;
    cause_i     = c;
    priv_i      = p;
    tval_i      = a + 32'h1000;
    iretire_i   = v;
    ilastsize_i = a[2];
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    int first;
    rst_ni = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    drv(1'b0, 32'h0, 3'd0, 5'd0, 2'd0);
    tick(); tick();
    check_eq("rst_valid", valid_o, 1'b0);
    check_eq("rst_mask", lane_valid_o, 2'b00);
    check_eq("rst_data", {iaddr_o, cause_o, priv_o}, '0);
    rst_ni = 1'b1; #1;
    check_eq("rst_ready", ready_o, 1'b1);

    // Four back-to-back entries form two full groups.
    tick();
    drv(1'b1, 32'h100, 3'd0, 5'd0, 2'd3);
    check_eq("g1_ready", ready_o, 1'b1);
    tick(); drv(1'b1, 32'h104, 3'd0, 5'd0, 2'd3);
    check_eq("g1_not_yet", valid_o, 1'b0);
    tick(); drv(1'b1, 32'h108, 3'd0, 5'd0, 2'd3);
    check_eq("g1_valid", valid_o, 1'b1);
    check_eq("g1_mask", lane_valid_o, 2'b11);
    check_eq("g1_addr", iaddr_o, {32'h104, 32'h100});
    check_eq("g1_tval", tval_o, 32'h1104);
    check_eq("g1_lastsize", ilastsize_o, 2'b10);
    tick(); drv(1'b1, 32'h10C, 3'd0, 5'd0, 2'd3);
    check_eq("g1_drop", valid_o, 1'b0);
    tick(); drv(1'b0, 32'h0, 3'd0, 5'd0, 2'd0);
    check_eq("g2_valid", valid_o, 1'b1);
    check_eq("g2_addr", iaddr_o, {32'h10C, 32'h108});
    tick();
    check_eq("g2_drop", valid_o, 1'b0);

    // Exception closes a single-lane group.
    drv(1'b1, 32'h200, ITYPE_EXC, 5'd2, 2'd3);
    tick(); drv(1'b0, 32'h0, 3'd0, 5'd0, 2'd0);
    check_eq("exc_valid", valid_o, 1'b1);
    check_eq("exc_mask", lane_valid_o, 2'b01);
    check_eq("exc_cause", cause_o, 5'd2);
    check_eq("exc_addr", iaddr_o, {32'h0, 32'h200});
    check_eq("exc_itype", itype_o, {3'd0, ITYPE_EXC});
    check_eq("exc_retire", iretire_o, 2'b01);
    tick(); tick();

    // Privilege change closes the open group and stalls the entry one cycle.
    drv(1'b1, 32'h300, 3'd0, 5'd0, 2'd3);
    tick(); drv(1'b1, 32'h304, 3'd0, 5'd0, 2'd0);
    check_eq("priv_stall", ready_o, 1'b0);
    tick(); #1;
    check_eq("priv_ready", ready_o, 1'b1);
    check_eq("priv_g1_valid", valid_o, 1'b1);
    check_eq("priv_g1_priv", priv_o, 2'd3);
    check_eq("priv_g1_mask", lane_valid_o, 2'b01);
    check_eq("priv_g1_addr", iaddr_o, {32'h0, 32'h300});
    tick(); drv(1'b0, 32'h0, 3'd0, 5'd0, 2'd0);
    check_eq("priv_g2_pending", valid_o, 1'b0);
    flush_i = 1'b1;
    tick(); flush_i = 1'b0; #1;
    check_eq("priv_g2_valid", valid_o, 1'b1);
    check_eq("priv_g2_priv", priv_o, 2'd0);
    check_eq("priv_g2_addr", iaddr_o, {32'h0, 32'h304});
    tick(); tick();

    // Backpressure: ready_i low for 5 cycles under continuous input.
    ready_i = 1'b0;
    drv(1'b1, 32'h400, 3'd0, 5'd0, 2'd1);
    tick(); drv(1'b1, 32'h404, 3'd0, 5'd0, 2'd1);
    tick(); drv(1'b1, 32'h408, 3'd0, 5'd0, 2'd1);
    check_eq("bp_c2_ready", ready_o, 1'b1);
    tick(); drv(1'b1, 32'h40C, 3'd0, 5'd0, 2'd1);
    check_eq("bp_c3_addr", iaddr_o, {32'h404, 32'h400});
    tick(); drv(1'b1, 32'h410, 3'd0, 5'd0, 2'd1);
    check_eq("bp_c4_ready", ready_o, 1'b0);
    check_eq("bp_c4_valid", valid_o, 1'b1);
    check_eq("bp_c4_addr", iaddr_o, {32'h404, 32'h400});
    tick(); ready_i = 1'b1; #1;
    check_eq("bp_c5_ready", ready_o, 1'b1);
    check_eq("bp_c5_addr", iaddr_o, {32'h404, 32'h400});
    tick(); drv(1'b1, 32'h414, 3'd0, 5'd0, 2'd1);
    check_eq("bp_c6_addr", iaddr_o, {32'h40C, 32'h408});
    tick(); drv(1'b0, 32'h0, 3'd0, 5'd0, 2'd0);
    check_eq("bp_c7_valid", valid_o, 1'b1);
    check_eq("bp_c7_addr", iaddr_o, {32'h414, 32'h410});
    tick();
    check_eq("bp_c8_drop", valid_o, 1'b0);
    tick();

    // Lone entry then idle.
    drv(1'b1, 32'h500, 3'd0, 5'd0, 2'd0);
    tick(); drv(1'b0, 32'h0, 3'd0, 5'd0, 2'd0);
`ifdef MURE_PACKER_TIMEOUT_EN
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      if (valid_o && first == 0) first = k;
      tick();
    end
    check_eq("tmo_latency", first, 9);
`else
    seen = 0;
    for (int k = 1; k <= 12; k++) begin
      if (valid_o) seen++;
      tick();
    end
    check_eq("no_tmo_idle", seen, 0);
    flush_i = 1'b1;
    tick(); flush_i = 1'b0; #1;
    check_eq("flush_valid", valid_o, 1'b1);
    check_eq("flush_addr", iaddr_o, {32'h0, 32'h500});
    tick();
`endif
    tick();

    // Reset with one entry buffered discards it.
    drv(1'b1, 32'h600, 3'd0, 5'd0, 2'd0);
    tick(); drv(1'b0, 32'h0, 3'd0, 5'd0, 2'd0);
    rst_ni = 1'b0;
    tick(); rst_ni = 1'b1; #1;
    check_eq("rst2_valid", valid_o, 1'b0);
    check_eq("rst2_ready", ready_o, 1'b1);
    flush_i = 1'b1;
    tick(); flush_i = 1'b0; #1;
    check_eq("rst2_flush_empty", valid_o, 1'b0);
    drv(1'b1, 32'h700, 3'd0, 5'd0, 2'd0);
    tick(); drv(1'b1, 32'h704, 3'd0, 5'd0, 2'd0);
    tick(); drv(1'b0, 32'h0, 3'd0, 5'd0, 2'd0);
    check_eq("rst2_next_addr", iaddr_o, {32'h704, 32'h700});
    check_eq("rst2_next_mask", lane_valid_o, 2'b11);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/retire_packer.md
RETIRE_PACKER -- requirements
Module: retire_packer

Interface
REQ-001 Parameter NrRetiredInstr, default 2, SHALL set the number of output lanes per group (>=2).
REQ-002 Parameter TimeoutCycles, default 8, SHALL set the partial-group idle timeout in cycles (>=1, used only when the timeout feature is compiled in).
REQ-003 Ports SHALL be, in order:
- clk_i  in  1  clock
- rst_ni  in  1  reset, active-low; synchronous to clk_i (decided)
- valid_i  in  1  serial entry valid
- ready_o  out  1  serial entry accepted when valid_i && ready_o
- iretire_i  in  1  per-entry retire field
- ilastsize_i  in  1  per-entry last-size field
- itype_i  in  mure_pkg::ITYPE_LEN  per-entry instruction type
- iaddr_i  in  mure_pkg::XLEN  per-entry instruction address
- cause_i  in  mure_pkg::CAUSE_LEN  common cause field
- tval_i  in  mure_pkg::TVAL_LEN  common trap value
- priv_i  in  mure_pkg::PRIV_LEN  common privilege
- flush_i  in  1  force-close the open partial group
- valid_o  out  1  group valid
- ready_i  in  1  group consumed when valid_o && ready_i
- lane_valid_o  out  NrRetiredInstr  per-lane occupancy mask
- iretire_o, ilastsize_o  out  NrRetiredInstr each  per-lane fields
- itype_o  out  NrRetiredInstr x ITYPE_LEN  per-lane fields
- iaddr_o  out  NrRetiredInstr x XLEN  per-lane fields
- cause_o, tval_o, priv_o  out  package widths  group common fields

Function
REQ-004 The block SHALL repack a one-entry-per-cycle serial retirement stream into groups of up to NrRetiredInstr lanes, filling from lane 0 in arrival order.
REQ-005 The block SHALL hold two stages: a fill buffer (lanes, count cnt, common fields) and an output register driving all *_o group ports.
REQ-006 The fill buffer SHALL have the states EMPTY (cnt=0), PARTIAL (0<cnt<N), CLOSED (group complete, awaiting transfer).
REQ-007 The common fields cause/tval/priv of a group SHALL be taken from the most recently accepted entry of that group.
REQ-008 An accepted entry SHALL close the group, itself included, when cnt reaches NrRetiredInstr or itype_i equals mure_pkg::ITYPE_EXC or mure_pkg::ITYPE_INT.
REQ-009 On valid_i in PARTIAL with priv_i differing from the group priv, ready_o SHALL be 0, the group SHALL close that cycle, and the entry SHALL be accepted on a later cycle into an empty fill buffer.
REQ-010 flush_i in PARTIAL SHALL close the group that cycle; an entry accepted in the same cycle SHALL be included before closing; flush_i in EMPTY SHALL have no effect.
REQ-011 A CLOSED group SHALL transfer to the output register in the same cycle if valid_o=0 or (valid_o && ready_i); valid_o SHALL rise on the next cycle, a latency of 1 cycle from the closing accept.
REQ-012 ready_o SHALL be 0 while the fill buffer is CLOSED and not transferring that cycle; otherwise ready_o SHALL be 1 except as stated in REQ-009.
REQ-013 Output lanes at index >= the group count SHALL read zero, and lane_valid_o SHALL be a contiguous low-aligned mask.
REQ-014 The output register SHALL hold its content stable while valid_o && !ready_i.
REQ-015 When the output register is consumed with no new transfer, valid_o SHALL drop on the next cycle.
REQ-016 Entries SHALL never be dropped, duplicated or reordered, and sustained throughput with ready_i=1 SHALL be one entry per cycle.

Reset
REQ-017 With rst_ni=0 at a clock edge, the fill buffer SHALL become EMPTY, cnt and the timeout counter SHALL become 0, and valid_o, lane_valid_o and all data outputs SHALL become 0.
REQ-018 ready_o SHALL be 1 in the first cycle after reset release.
REQ-019 Reset mid-group SHALL discard all buffered entries.

Configuration
REQ-020 With MURE_PACKER_TIMEOUT_EN defined, a counter SHALL count cycles in PARTIAL without an accept, clear on every accept, and close the group when it reaches TimeoutCycles.
REQ-021 Without MURE_PACKER_TIMEOUT_EN, no timeout counter SHALL exist, and partial groups SHALL close only via REQ-008, REQ-009 and REQ-010.

Structure
REQ-022 ITYPE_LEN, XLEN, CAUSE_LEN, TVAL_LEN, PRIV_LEN, ITYPE_EXC, ITYPE_INT, uop_entry_s and common_entry_s SHALL reside in mure_pkg.
REQ-023 The fill-state encoding SHALL be a typedef in mure_pkg.
REQ-024 The block SHALL contain a single module with no sub-module; the timeout counter SHALL be inline.

Verification
REQ-025 N=2, ready_i=1, four entries with iaddr 0x100, 0x104, 0x108, 0x10C on consecutive cycles -> two groups, lane_valid_o=2'b11, each valid_o 1 cycle after its second accept.
REQ-026 Entry at 0x200 with itype=ITYPE_EXC, cause=2 -> group with lane_valid_o=2'b01, cause_o=2, lane 1 all zero.
REQ-027 Entry at priv=3, then an entry at priv=0 -> ready_o=0 for 1 cycle, then groups {priv_o=3, mask 01} and {priv_o=0}.
REQ-028 ready_i=0 held for 5 cycles under continuous input -> ready_o=0 after two groups are buffered, output stable, no loss after ready_i returns to 1.
REQ-029 Single entry then idle, with the timeout feature compiled in and TimeoutCycles=8 -> valid_o asserts 9 cycles after the accept; without the feature -> no valid_o until flush_i, then valid_o the following cycle.
REQ-030 rst_ni=0 asserted with one entry buffered -> valid_o=0, ready_o=1 after release, and the dropped entry never appears.
